// File: rtl/clap_sequence_decoder.sv
// clap_sequence_decoder: groups clap pulses into a clap-count command on a valid/ready port.
// Define CLAP_SEQ_LAMP_EN to build the lamp toggled by two-clap commands.
module clap_sequence_decoder #(
  parameter int GAP_MIN = 150_000,
  parameter int GAP_MAX = 1_500_000,
  parameter int MAX_CLAPS = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clap_i,
  output logic [2:0] cmd_o,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic       busy_o,
  output logic       lamp_o
);
  localparam int TW = $clog2(GAP_MAX + 1);
  localparam logic [TW-1:0] T_MIN = TW'(GAP_MIN);
  localparam logic [TW-1:0] T_MAX = TW'(GAP_MAX);
  localparam logic [2:0] C_MAX = 3'(MAX_CLAPS);
  typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;
  state_t state;
  logic [2:0] cnt;
  logic [TW-1:0] timer;
  logic [2:0] cnt_nx;
  logic accept, handshake;
  assign cnt_nx = cnt + 3'd1;
  assign accept = clap_i && timer >= T_MIN;
  assign handshake = cmd_valid_o && cmd_ready_i;
  assign busy_o = state != IDLE;
  assign cmd_o = cmd_valid_o ? cnt : 3'd0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt <= '0;
      timer <= '0;
      cmd_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (clap_i) begin
          state <= COUNT;
          cnt <= 3'd1;
          timer <= '0;
        end
        COUNT: if (accept) begin
          cnt <= cnt_nx;
          timer <= '0;
          if (cnt_nx == C_MAX) begin
            state <= REPORT;
            cmd_valid_o <= 1'b1;
          end
        end else if (timer == T_MAX) begin
          state <= REPORT;
          cmd_valid_o <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
        REPORT: if (handshake) begin
          state <= IDLE;
          cnt <= '0;
          cmd_valid_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CLAP_SEQ_LAMP_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lamp_o <= 1'b0;
    else if (handshake && cmd_o == 3'd2) lamp_o <= ~lamp_o;
  end
`else
  assign lamp_o = 1'b0;
`endif
endmodule

// File: tb/tb_clap_sequence_decoder.sv
// tb_clap_sequence_decoder: directed checks of clap grouping, timeout, max count, handshake and reset.
module tb_clap_sequence_decoder;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic clap_i = 1'b0;
  logic cmd_ready_i = 1'b1;
  logic [2:0] cmd_o;
  logic cmd_valid_o, busy_o, lamp_o;
  int tests = 0;
  int fails = 0;
  int e = 0;
  logic seen_valid;
`ifdef CLAP_SEQ_LAMP_EN
  localparam logic LAMP_ON = 1'b1;
`else
  localparam logic LAMP_ON = 1'b0;
`endif

  clap_sequence_decoder #(.GAP_MIN(4), .GAP_MAX(20), .MAX_CLAPS(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clap_i(clap_i), .cmd_o(cmd_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .busy_o(busy_o), .lamp_o(lamp_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_to(input int k);
    while (e < k) begin
      @(posedge clk_i);
      #1;
      e++;
    end
  endtask

  task automatic clap_at(input int k);
    run_to(k - 1);
    clap_i = 1'b1;
    run_to(k);
    clap_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    clap_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    e = 0;
  endtask

  initial begin
    do_reset();
    check("rst_busy", {3'd0, busy_o}, 4'd0);
    check("rst_valid", {3'd0, cmd_valid_o}, 4'd0);
    check("rst_cmd", {1'b0, cmd_o}, 4'd0);
    check("rst_lamp", {3'd0, lamp_o}, 4'd0);
    // single clap: timeout closes the sequence GAP_MAX+1 edges later
    run_to(9);
    check("s1_busy_before", {3'd0, busy_o}, 4'd0);
    clap_at(10);
    check("s1_busy_after", {3'd0, busy_o}, 4'd1);
    run_to(30);
    check("s1_valid_early", {3'd0, cmd_valid_o}, 4'd0);
    run_to(31);
    check("s1_valid", {3'd0, cmd_valid_o}, 4'd1);
    check("s1_cmd", {1'b0, cmd_o}, 4'd1);
    run_to(32);
    check("s1_valid_fall", {3'd0, cmd_valid_o}, 4'd0);
    check("s1_cmd_zero", {1'b0, cmd_o}, 4'd0);
    check("s1_busy_low", {3'd0, busy_o}, 4'd0);
    // two claps, twice in a row: lamp toggles on and back off
    do_reset();
    clap_at(10);
    clap_at(16);
    run_to(36);
    check("s2_valid_early", {3'd0, cmd_valid_o}, 4'd0);
    run_to(37);
    check("s2_valid", {3'd0, cmd_valid_o}, 4'd1);
    check("s2_cmd", {1'b0, cmd_o}, 4'd2);
    check("s2_lamp_pre", {3'd0, lamp_o}, 4'd0);
    run_to(38);
    check("s2_lamp_on", {3'd0, lamp_o}, {3'd0, LAMP_ON});
    e = 0;
    clap_at(10);
    clap_at(16);
    run_to(37);
    check("s2b_cmd", {1'b0, cmd_o}, 4'd2);
    run_to(38);
    check("s2b_lamp_off", {3'd0, lamp_o}, 4'd0);
    // echoes neither count nor restart the timer
    do_reset();
    clap_at(10);
    clap_at(12);
    clap_at(13);
    run_to(30);
    check("s3_valid_early", {3'd0, cmd_valid_o}, 4'd0);
    run_to(31);
    check("s3_valid", {3'd0, cmd_valid_o}, 4'd1);
    check("s3_cmd", {1'b0, cmd_o}, 4'd1);
    // max count closes immediately; clap during REPORT ignored
    do_reset();
    clap_at(10);
    clap_at(15);
    run_to(19);
    check("s4_valid_early", {3'd0, cmd_valid_o}, 4'd0);
    clap_at(20);
    check("s4_valid", {3'd0, cmd_valid_o}, 4'd1);
    check("s4_cmd", {1'b0, cmd_o}, 4'd3);
    clap_at(21);
    check("s4_valid_fall", {3'd0, cmd_valid_o}, 4'd0);
    check("s4_busy_21", {3'd0, busy_o}, 4'd0);
    run_to(22);
    check("s4_busy_22", {3'd0, busy_o}, 4'd0);
    // back-pressure: command held while claps arrive
    do_reset();
    cmd_ready_i = 1'b0;
    clap_at(10);
    clap_at(16);
    run_to(37);
    check("s5_valid", {3'd0, cmd_valid_o}, 4'd1);
    check("s5_cmd", {1'b0, cmd_o}, 4'd2);
    for (int k = 40; k <= 86; k += 7) clap_at(k);
    run_to(87);
    check("s5_valid_held", {3'd0, cmd_valid_o}, 4'd1);
    check("s5_cmd_held", {1'b0, cmd_o}, 4'd2);
    check("s5_busy_held", {3'd0, busy_o}, 4'd1);
    cmd_ready_i = 1'b1;
    run_to(88);
    check("s5_valid_fall", {3'd0, cmd_valid_o}, 4'd0);
    check("s5_busy_low", {3'd0, busy_o}, 4'd0);
    check("s5_lamp", {3'd0, lamp_o}, {3'd0, LAMP_ON});
    run_to(89);
    check("s5_idle", {3'd0, busy_o}, 4'd0);
    // asynchronous reset mid-COUNT, lamp possibly on
    e = 0;
    clap_at(10);
    clap_at(16);
    run_to(17);
    #2;
    rst_ni = 1'b0;
    #1;
    check("s6_busy_async", {3'd0, busy_o}, 4'd0);
    check("s6_valid_async", {3'd0, cmd_valid_o}, 4'd0);
    check("s6_cmd_async", {1'b0, cmd_o}, 4'd0);
    check("s6_lamp_async", {3'd0, lamp_o}, 4'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    e = 0;
    seen_valid = 1'b0;
    while (e < 40) begin
      run_to(e + 1);
      seen_valid = seen_valid | cmd_valid_o | busy_o;
    end
    check("s6_no_command", {3'd0, seen_valid}, 4'd0);
    clap_at(45);
    check("s6_new_busy", {3'd0, busy_o}, 4'd1);
    run_to(66);
    check("s6_new_valid", {3'd0, cmd_valid_o}, 4'd1);
    check("s6_new_cmd", {1'b0, cmd_o}, 4'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
